// File: rtl/nn_mem_arbiter_if.sv
// rtl/nn_mem_arbiter_if.sv - requester, memory and status signals of the memory arbiter
interface nn_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] in_addr;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_rdata;
  logic                  in_rvalid;
  logic [ADDR_WIDTH-1:0] wt_addr;
  logic                  wt_valid;
  logic                  wt_ready;
  logic [DATA_WIDTH-1:0] wt_rdata;
  logic                  wt_rvalid;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_wdata;
  logic                  out_valid;
  logic                  out_ready;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  busy;
  logic                  timeout_err;
  logic [31:0]           txn_count;

  // Arbiter side
  modport slave (
    input  in_addr, in_valid, wt_addr, wt_valid, out_addr, out_wdata, out_valid,
           mem_gnt, mem_rvalid, mem_rdata,
    output in_ready, in_rdata, in_rvalid, wt_ready, wt_rdata, wt_rvalid, out_ready,
           mem_req, mem_we, mem_addr, mem_wdata, busy, timeout_err, txn_count
  );

  // Requester / memory side
  modport master (
    output in_addr, in_valid, wt_addr, wt_valid, out_addr, out_wdata, out_valid,
           mem_gnt, mem_rvalid, mem_rdata,
    input  in_ready, in_rdata, in_rvalid, wt_ready, wt_rdata, wt_rvalid, out_ready,
           mem_req, mem_we, mem_addr, mem_wdata, busy, timeout_err, txn_count
  );
endinterface

// File: rtl/nn_mem_arbiter.sv
// rtl/nn_mem_arbiter.sv - round-robin arbiter sharing one memory port among three accelerator streams
module nn_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              reset,
  nn_mem_arbiter_if.slave   bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

  state_t                state, state_next;
  logic [1:0]            ptr;
  logic [1:0]            sel;
  logic [TW-1:0]         tcnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] in_rdata_q, wt_rdata_q;
  logic                  in_rv_q, wt_rv_q;
  logic [31:0]           txn_q;
  logic                  err_q;

  logic [2:0]            valid_vec;
  logic [2:0]            cand;
  logic [2:0]            shifted;
  logic                  pick_found;
  logic [1:0]            pick_idx;
  logic                  grant;
  logic                  timeout_hit;
  logic [DATA_WIDTH-1:0] ret_data;

  assign valid_vec = {bus.out_valid, bus.wt_valid, bus.in_valid};

  // Return data: real memory data, or the poison word when the read timed out
  assign ret_data = bus.mem_rvalid ? bus.mem_rdata : DATA_WIDTH'(32'hDEADBEEF);

  // Round-robin scan starting at the pointer; first valid requester wins
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    cand       = 3'd0;
    shifted    = 3'd0;
    for (int i = 0; i < 3; i++) begin
      cand = {1'b0, ptr} + 3'(i);
      if (cand >= 3'd3) cand = cand - 3'd3;
      shifted = valid_vec >> cand;
      if (!pick_found && shifted[0]) begin
        pick_found = 1'b1;
        pick_idx   = cand[1:0];
      end
    end
  end

  // Ready is a combinational accept pulse in the arbitration cycle only
  always_comb begin
    grant         = (state == IDLE) && pick_found && !reset;
    bus.in_ready  = grant && (pick_idx == 2'd0);
    bus.wt_ready  = grant && (pick_idx == 2'd1);
    bus.out_ready = grant && (pick_idx == 2'd2);
  end

  // Next-state logic; rvalid takes priority over the timeout in the same cycle
  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE:      if (pick_found) state_next = ISSUE;
      ISSUE:     if (bus.mem_gnt) state_next = we_q ? IDLE : WAIT_RESP;
      WAIT_RESP: begin
        if (bus.mem_rvalid) begin
          state_next = IDLE;
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      default:   state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Request latch, timeout counter, response return and statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= 2'd0;
      sel        <= 2'd0;
      tcnt       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      in_rdata_q <= '0;
      wt_rdata_q <= '0;
      in_rv_q    <= 1'b0;
      wt_rv_q    <= 1'b0;
      txn_q      <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      in_rv_q <= 1'b0;
      wt_rv_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            sel  <= pick_idx;
            ptr  <= (pick_idx == 2'd2) ? 2'd0 : pick_idx + 2'd1;
            we_q <= (pick_idx == 2'd2);
            case (pick_idx)
              2'd0:    addr_q <= bus.in_addr;
              2'd1:    addr_q <= bus.wt_addr;
              default: begin
                addr_q  <= bus.out_addr;
                wdata_q <= bus.out_wdata;
              end
            endcase
          end
        end
        ISSUE: begin
          if (bus.mem_gnt) begin
            tcnt <= '0;
            if (we_q) txn_q <= txn_q + 32'd1;
          end
        end
        WAIT_RESP: begin
          tcnt <= tcnt + 1'b1;
          if (bus.mem_rvalid || timeout_hit) begin
            if (sel == 2'd1) begin
              wt_rdata_q <= ret_data;
              wt_rv_q    <= 1'b1;
            end else begin
              in_rdata_q <= ret_data;
              in_rv_q    <= 1'b1;
            end
            if (bus.mem_rvalid) txn_q <= txn_q + 32'd1;
            else                err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req     = (state == ISSUE);
  assign bus.mem_we      = we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.in_rdata    = in_rdata_q;
  assign bus.in_rvalid   = in_rv_q;
  assign bus.wt_rdata    = wt_rdata_q;
  assign bus.wt_rvalid   = wt_rv_q;
  assign bus.busy        = (state != IDLE);
  assign bus.timeout_err = err_q;
  assign bus.txn_count   = txn_q;
endmodule

// File: doc/nn_mem_arbiter.md
Name: nn_mem_arbiter

Overview:
- Shares one external memory port among the three streams of the neural accelerator: input read (requester 0), weight read (requester 1) and output write (requester 2).
- Arbitration is round-robin. At most one transaction is outstanding at a time.
- Adds a response timeout with error reporting, and a transaction counter for performance monitoring.
- Sits between the accelerator's memory interfaces and the AXI/BRAM bridge.

Parameters:
ADDR_WIDTH, 32, address width of all requester and memory addresses
DATA_WIDTH, 32, data width of all read and write data
TIMEOUT_CYCLES, 256, cycles allowed in WAIT_RESP before a timeout is declared (must be ≥2)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
in_addr  in  ADDR_WIDTH  requester 0 read address
in_valid  in  1  requester 0 request
in_ready  out  1  requester 0 request accepted (one-cycle pulse)
in_rdata  out  DATA_WIDTH  requester 0 read data
in_rvalid  out  1  requester 0 read data valid (one-cycle pulse)
wt_addr  in  ADDR_WIDTH  requester 1 read address
wt_valid  in  1  requester 1 request
wt_ready  out  1  requester 1 request accepted
wt_rdata  out  DATA_WIDTH  requester 1 read data
wt_rvalid  out  1  requester 1 read data valid
out_addr  in  ADDR_WIDTH  requester 2 write address
out_wdata  in  DATA_WIDTH  requester 2 write data
out_valid  in  1  requester 2 request
out_ready  out  1  requester 2 request accepted
mem_req  out  1  memory request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_gnt  in  1  memory accepted the request
mem_rvalid  in  1  memory read data valid
mem_rdata  in  DATA_WIDTH  memory read data
busy  out  1  state is not IDLE
timeout_err  out  1  sticky flag: a read timed out
txn_count  out  32  completed transactions; wraps at 2^32

Behaviour:
- Reset values:
  - State IDLE, round-robin pointer = 0.
  - All ready/rvalid outputs, mem_req, mem_we, busy and timeout_err = 0.
  - mem_addr, mem_wdata, in_rdata, wt_rdata = 0; txn_count = 0.
- Reset mid-transaction: returns to IDLE immediately. Any later mem_gnt or mem_rvalid for the abandoned transaction is ignored.

State machine:
- IDLE:
  - Scan requesters starting at the pointer (pointer, pointer+1, pointer+2, all mod 3).
  - The first one with valid=1 is selected. Its ready is driven combinationally high in that same cycle; the other readys stay 0.
  - Selected addr (and out_wdata for requester 2) is latched into mem_addr/mem_wdata, and mem_we is set (1 only for requester 2).
  - Selected index is stored; pointer becomes (selected+1) mod 3. Next state is ISSUE.
  - No valid asserted: stay in IDLE, pointer unchanged.
- ISSUE:
  - mem_req = 1, with address, data and we held stable until mem_gnt = 1.
  - On mem_gnt with a write: txn_count increments and next state is IDLE. mem_req drops the cycle after gnt.
  - On mem_gnt with a read: next state is WAIT_RESP.
  - No timeout is applied in ISSUE.
- WAIT_RESP:
  - mem_req = 0. The timeout counter clears on entry and increments every cycle.
  - On mem_rvalid: mem_rdata is registered into in_rdata or wt_rdata (selected requester), that requester's rvalid pulses for exactly one cycle on the next edge, txn_count increments, next state is IDLE.
  - If the counter reaches TIMEOUT_CYCLES-1 without mem_rvalid:
    - Rdata is set to 32'hDEADBEEF and rvalid pulses.
    - timeout_err is set (cleared only by reset).
    - txn_count does not increment; next state is IDLE.
  - mem_rvalid and timeout in the same cycle: mem_rvalid wins and is treated as a normal completion.

Boundary conditions:
- Minimum latency: valid at cycle t → ready at t, mem_req at t+1. If gnt at t+1 and rvalid at t+2, rvalid to the requester occurs at t+3.
- A new grant can occur in the cycle IDLE is re-entered, giving back-to-back transactions.
- mem_rvalid or mem_gnt outside WAIT_RESP or ISSUE respectively is ignored.
- Requesters must hold valid/addr/wdata until ready. Deasserting valid before ready is permitted; no grant is issued.
- Rdata registers hold their last value between rvalid pulses.
- busy = 1 in ISSUE and WAIT_RESP.

Test Plan:
- Single read: reset, in_valid=1 with in_addr=0x100; memory gives gnt 1 cycle later and rvalid 2 cycles later with 0xA5A5_0001 → in_ready pulses in the request cycle, mem_addr=0x100 with mem_we=0, in_rvalid pulses once with in_rdata=0xA5A5_0001, txn_count=1.
- Round-robin fairness: all three valid continuously, memory zero-wait (gnt immediate, rvalid next cycle) → grant order 0,1,2,0,1,2. Writes show mem_we=1 with out_wdata=0xCAFE0000 at out_addr=0x200. txn_count=6 after six transactions.
- Timeout: wt_valid read and mem_gnt given, rvalid never arrives, TIMEOUT_CYCLES=16 → wt_rvalid pulses 16 cycles after entering WAIT_RESP with 0xDEADBEEF, timeout_err=1 and sticky, txn_count unchanged. A subsequent normal read succeeds.
- Gnt stall: mem_gnt held low 10 cycles → mem_req, mem_addr and mem_wdata stable all 10 cycles, no timeout_err, completion on gnt.
- Reset mid-transaction: assert reset while in WAIT_RESP, then send mem_rvalid one cycle after reset releases → no rvalid pulse, busy=0, pointer=0, txn_count=0.
- Simultaneous rvalid and timeout: rvalid arrives in the timeout cycle → normal data returned, timeout_err stays 0.
